// File: rtl/mor1kx_rdata_fifo.sv
// Flow-controlled FWFT read front end for a 1-cycle-latency RAM read port.
// Define MOR1KX_RDATA_FIFO_BYPASS_EN to present ram_dout directly when the buffer is empty.
module mor1kx_rdata_fifo #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    output logic [ADDR_WIDTH-1:0]  ram_addr,
    output logic                   ram_we,
    input  logic [DATA_WIDTH-1:0]  ram_dout,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_data,
    output logic [DEPTH_WIDTH:0]   level
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_WIDTH:0]   level_q, level_d;
    logic                   pending_q, pending_d;

    logic                   fire;
    logic                   capture;
    logic                   pop_stored;
    logic                   empty;
    logic                   clear;
    logic                   mem_we;
    logic [DEPTH_WIDTH+1:0] occupancy;

    // Space is reserved at issue time, so in-flight reads count toward occupancy.
    assign occupancy = {1'b0, level_q} + {{(DEPTH_WIDTH+1){1'b0}}, pending_q};
    assign req_ready = rst_n & ~flush & (occupancy < (DEPTH_WIDTH+2)'(DEPTH));
    assign fire      = req_valid & req_ready;
    assign ram_addr  = req_addr;
    assign ram_we    = 1'b0;
    assign clear     = ~rst_n | flush;
    assign empty     = (level_q == '0);
    assign level     = level_q;

`ifdef MOR1KX_RDATA_FIFO_BYPASS_EN
    logic bypass;
    assign bypass    = empty & pending_q;
    assign rsp_valid = ~empty | bypass;
    assign rsp_data  = bypass ? ram_dout : mem_q[rd_ptr_q];
    // A bypassed word taken by the consumer is never stored.
    assign capture   = pending_q & ~(bypass & rsp_ready);
`else
    assign rsp_valid = ~empty;
    assign rsp_data  = mem_q[rd_ptr_q];
    assign capture   = pending_q;
`endif

    assign pop_stored = ~empty & rsp_ready;
    assign mem_we     = capture & ~clear;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        pending_d = fire;
        if (capture) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_stored) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({capture, pop_stored})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        // Flush and reset drop both buffered entries and the read in flight.
        if (clear) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            pending_q <= pending_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (mem_we && (wr_ptr_q == DEPTH_WIDTH'(gi))) begin
                    mem_q[gi] <= ram_dout;
                end
            end
        end
    endgenerate

endmodule
